// File: rtl/instr_align_buffer.sv
// instr_align_buffer: aligns fetch blocks on the fetch PC, tags each surviving
// instruction with its own PC, queues them in a circular buffer and presents
// up to DEC_WIDTH of them per cycle to decode.
// Ports:
//   clock, reset_n            rising-edge clock, asynchronous active-low reset
//   flush                     drop buffered and incoming instructions
//   fetch_valid/fetch_ready   fetch block handshake (ready from registered count)
//   fetch_instr, fetch_pc     FETCH_WIDTH lanes, PC of first wanted lane
//   dec_valid/instr/pc        oldest-first decode lanes, valid contiguous from 0
//   dec_ready                 decode consumes every valid lane this cycle
// Optional: ALIGN_BUF_BYPASS_EN forwards an incoming block straight to decode
// when the buffer is empty.
module instr_align_buffer #(
  parameter int FETCH_WIDTH = 2,
  parameter int DEC_WIDTH   = 2,
  parameter int DEPTH       = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     fetch_valid,
  output logic                     fetch_ready,
  input  logic [32*FETCH_WIDTH-1:0] fetch_instr,
  input  logic [63:0]              fetch_pc,
  output logic [DEC_WIDTH-1:0]     dec_valid,
  output logic [32*DEC_WIDTH-1:0]  dec_instr,
  output logic [64*DEC_WIDTH-1:0]  dec_pc,
  input  logic                     dec_ready
);
  localparam int L = $clog2(FETCH_WIDTH);
  localparam int P = $clog2(DEPTH);
  localparam int C = P + 1;
  logic [P-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [C-1:0] count_q, count_d;
  logic [31:0]  instr_mem [DEPTH];
  logic [63:0]  pc_mem [DEPTH];
  logic [63:0]  lane_pc [FETCH_WIDTH];
  logic [L-1:0] off, lane;
  logic [C-1:0] n_in, n_byp, n_store, n_pop;
  logic         push, pop, byp;
  logic         unused_pc_lsb;
  assign unused_pc_lsb = ^fetch_pc[1:0];
  assign off = fetch_pc[L+1:2];
  assign n_in = C'(FETCH_WIDTH) - C'(off);
  assign fetch_ready = count_q <= C'(DEPTH - FETCH_WIDTH);
  assign push = fetch_valid && fetch_ready && !flush;
  assign pop = dec_ready && !flush;
`ifdef ALIGN_BUF_BYPASS_EN
  assign byp = push && count_q == '0;
`else
  assign byp = 1'b0;
`endif
  always_comb
    for (int i = 0; i < FETCH_WIDTH; i++)
      lane_pc[i] = {fetch_pc[63:L+2], L'(i), 2'b00};
  // Lanes consumed directly by decode through the bypass are never stored.
  always_comb begin
    n_pop = pop ? (count_q < C'(DEC_WIDTH) ? count_q : C'(DEC_WIDTH)) : '0;
    n_byp = (byp && dec_ready) ? (n_in < C'(DEC_WIDTH) ? n_in : C'(DEC_WIDTH)) : '0;
    n_store = push ? n_in - n_byp : '0;
    count_d = flush ? '0 : count_q + n_store - n_pop;
    wr_ptr_d = flush ? '0 : wr_ptr_q + n_store[P-1:0];
    rd_ptr_d = flush ? '0 : rd_ptr_q + n_pop[P-1:0];
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  always_ff @(posedge clock)
    for (int i = 0; i < FETCH_WIDTH; i++)
      if (push && i >= int'(off) + int'(n_byp)) begin
        instr_mem[wr_ptr_q + P'(i) - P'(off) - n_byp[P-1:0]] <= fetch_instr[32*i +: 32];
        pc_mem[wr_ptr_q + P'(i) - P'(off) - n_byp[P-1:0]]    <= lane_pc[i];
      end
  always_comb begin
    dec_valid = '0;
    dec_instr = '0;
    dec_pc    = '0;
    lane      = '0;
    for (int j = 0; j < DEC_WIDTH; j++) begin
      lane = off + L'(j);
      if (byp) begin
        if (C'(j) < n_in) begin
          dec_valid[j]         = 1'b1;
          dec_instr[32*j +: 32] = fetch_instr[32*lane +: 32];
          dec_pc[64*j +: 64]    = lane_pc[lane];
        end
      end else if (C'(j) < count_q && !flush) begin
        dec_valid[j]         = 1'b1;
        dec_instr[32*j +: 32] = instr_mem[rd_ptr_q + P'(j)];
        dec_pc[64*j +: 64]    = pc_mem[rd_ptr_q + P'(j)];
      end
    end
  end
endmodule

// File: tb/tb_instr_align_buffer.sv
// tb_instr_align_buffer: randomized and directed checks of instr_align_buffer
// against a queue-based reference model of the alignment buffer.
module tb_instr_align_buffer;
  localparam int FW = 2;
  localparam int DW = 2;
  localparam int D  = 8;
`ifdef ALIGN_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  logic fetch_valid = 1'b0;
  logic dec_ready = 1'b0;
  logic fetch_ready;
  logic [32*FW-1:0] fetch_instr = '0;
  logic [63:0] fetch_pc = '0;
  logic [DW-1:0] dec_valid;
  logic [32*DW-1:0] dec_instr;
  logic [64*DW-1:0] dec_pc;
  logic [DW-1:0] exp_valid;
  logic [32*DW-1:0] exp_instr;
  logic [64*DW-1:0] exp_pc;
  logic exp_ready;
  logic [31:0] mq_i[$];
  logic [63:0] mq_p[$];
  int checks = 0;
  int errors = 0;

  instr_align_buffer #(.FETCH_WIDTH(FW), .DEC_WIDTH(DW), .DEPTH(D)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_ready(dec_ready)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] lane_pc(input logic [63:0] pc, input int k);
    return (pc & ~(64'(4*FW) - 64'd1)) + 64'(4*k);
  endfunction

  function automatic int offset_of(input logic [63:0] pc);
    return int'((pc >> 2) % FW);
  endfunction

  function automatic logic [32*FW-1:0] rand_block();
    logic [32*FW-1:0] b;
    for (int k = 0; k < FW; k++) b[32*k +: 32] = $urandom;
    return b;
  endfunction

  // Drive one cycle of inputs at the falling edge and predict the outputs.
  task automatic drive(input logic fv, input logic [63:0] pc, input logic [32*FW-1:0] ins,
                       input logic dr, input logic fl);
    int off, sz;
    @(negedge clock);
    fetch_valid = fv; fetch_pc = pc; fetch_instr = ins; dec_ready = dr; flush = fl;
    off = offset_of(pc);
    sz = mq_i.size();
    exp_ready = (D - sz) >= FW;
    exp_valid = '0; exp_instr = '0; exp_pc = '0;
    if (!fl) begin
      if (BYP && sz == 0 && fv && exp_ready) begin
        for (int j = 0; j < DW && off + j < FW; j++) begin
          exp_valid[j] = 1'b1;
          exp_instr[32*j +: 32] = ins[32*(off+j) +: 32];
          exp_pc[64*j +: 64] = lane_pc(pc, off + j);
        end
      end else begin
        for (int j = 0; j < DW && j < sz; j++) begin
          exp_valid[j] = 1'b1;
          exp_instr[32*j +: 32] = mq_i[j];
          exp_pc[64*j +: 64] = mq_p[j];
        end
      end
    end
    #1;
  endtask

  // Advance through the rising edge and apply the same cycle to the model.
  task automatic tick();
    int off, sz, skip, n;
    bit push;
    sz = mq_i.size();
    off = offset_of(fetch_pc);
    n = FW - off;
    push = fetch_valid && exp_ready && !flush;
    @(posedge clock);
    if (flush) begin
      mq_i.delete(); mq_p.delete();
    end else begin
      skip = (BYP && sz == 0 && push && dec_ready) ? (n < DW ? n : DW) : 0;
      if (dec_ready)
        for (int j = 0; j < DW && mq_i.size() > 0; j++) begin
          void'(mq_i.pop_front()); void'(mq_p.pop_front());
        end
      if (push)
        for (int k = off + skip; k < FW; k++) begin
          mq_i.push_back(fetch_instr[32*k +: 32]);
          mq_p.push_back(lane_pc(fetch_pc, k));
        end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({fetch_ready, dec_valid, dec_instr, dec_pc} !== {1'b1, {DW{1'b0}}, {32*DW{1'b0}}, {64*DW{1'b0}}}) begin
      errors++;
      $display("FAIL reset: got rdy=%b v=%b i=%h pc=%h, expected rdy=1 and all dec outputs 0", fetch_ready, dec_valid, dec_instr, dec_pc);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_aligned();
    drive(0, 0, '0, 0, 1); tick();
    drive(1, 64'h1000, {32'hB, 32'hA}, 0, 0);
    checks++;
    if ({fetch_ready, dec_valid, dec_instr, dec_pc} !== {exp_ready, exp_valid, exp_instr, exp_pc}) begin
      errors++;
      $display("FAIL aligned_push: got rdy=%b v=%b i=%h pc=%h, expected rdy=%b v=%b i=%h pc=%h", fetch_ready, dec_valid, dec_instr, dec_pc, exp_ready, exp_valid, exp_instr, exp_pc);
    end
    tick();
    drive(0, 0, '0, 1, 0);
    checks++;
    if ({dec_valid, dec_instr, dec_pc} !== {2'b11, 32'hB, 32'hA, 64'h1004, 64'h1000}) begin
      errors++;
      $display("FAIL aligned_dec: got v=%b i=%h pc=%h, expected v=11 i=0000000b0000000a pc=00000000000010040000000000001000", dec_valid, dec_instr, dec_pc);
    end
    tick();
    drive(0, 0, '0, 0, 0);
    checks++;
    if ({fetch_ready, dec_valid} !== {1'b1, 2'b00}) begin
      errors++;
      $display("FAIL aligned_drained: got rdy=%b v=%b, expected rdy=1 v=00", fetch_ready, dec_valid);
    end
    tick();
  endtask

  task automatic test_misaligned();
    drive(0, 0, '0, 0, 1); tick();
    drive(1, 64'h1004, {32'hB, 32'hA}, 0, 0); tick();
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, '0, c == 1, 0);
      checks++;
      if ({dec_valid, dec_instr, dec_pc} !== {exp_valid, exp_instr, exp_pc} ||
          dec_valid !== (c < 2 ? 2'b01 : 2'b00) || (c < 2 && dec_pc[63:0] !== 64'h1004)) begin
        errors++;
        $display("FAIL misaligned c%0d: got v=%b i=%h pc=%h, expected v=%b i=%h pc=%h", c, dec_valid, dec_instr, dec_pc, exp_valid, exp_instr, exp_pc);
      end
      tick();
    end
  endtask

  task automatic test_fill();
    drive(0, 0, '0, 0, 1); tick();
    for (int c = 0; c < 8; c++) begin
      if (c < 5) drive(1, 64'h4000 + 64'(8*c), rand_block(), 0, 0);
      else if (c == 5) drive(1, 64'h4028, rand_block(), 1, 0);
      else drive(0, 0, '0, 0, 0);
      checks++;
      if ({fetch_ready, dec_valid, dec_instr, dec_pc} !== {exp_ready, exp_valid, exp_instr, exp_pc} ||
          fetch_ready !== (c < 4 || c > 5)) begin
        errors++;
        $display("FAIL fill c%0d: got rdy=%b v=%b i=%h pc=%h, expected rdy=%b v=%b i=%h pc=%h", c, fetch_ready, dec_valid, dec_instr, dec_pc, exp_ready, exp_valid, exp_instr, exp_pc);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    drive(0, 0, '0, 0, 1); tick();
    for (int c = 0; c < 24; c++) begin
      if (c < 20) drive(1, 64'h3000 + 64'(8*c) + ((c % 2) ? 64'h4 : 64'h0), rand_block(), 1, 0);
      else drive(0, 0, '0, 1, 0);
      checks++;
      if ({fetch_ready, dec_valid, dec_instr, dec_pc} !== {exp_ready, exp_valid, exp_instr, exp_pc}) begin
        errors++;
        $display("FAIL wrap c%0d: got rdy=%b v=%b i=%h pc=%h, expected rdy=%b v=%b i=%h pc=%h", c, fetch_ready, dec_valid, dec_instr, dec_pc, exp_ready, exp_valid, exp_instr, exp_pc);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    drive(0, 0, '0, 0, 1); tick();
    drive(1, 64'h1000, rand_block(), 0, 0); tick();
    drive(1, 64'h1008, rand_block(), 0, 0); tick();
    drive(1, 64'h100c, rand_block(), 0, 0); tick();
    for (int c = 0; c < 4; c++) begin
      if (c == 0) drive(1, 64'h5000, {32'hDEAD0001, 32'hDEAD0000}, 1, 1);
      else drive(0, 0, '0, 1, 0);
      checks++;
      if ({fetch_ready, dec_valid, dec_instr, dec_pc} !== {exp_ready, exp_valid, exp_instr, exp_pc} ||
          dec_valid !== 2'b00 || (c > 0 && fetch_ready !== 1'b1)) begin
        errors++;
        $display("FAIL flush c%0d: got rdy=%b v=%b i=%h pc=%h, expected rdy=%b v=%b i=%h pc=%h", c, fetch_ready, dec_valid, dec_instr, dec_pc, exp_ready, exp_valid, exp_instr, exp_pc);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    drive(0, 0, '0, 0, 1); tick();
    drive(1, 64'h6000, rand_block(), 0, 0); tick();
    drive(1, 64'h6008, rand_block(), 0, 0); tick();
    drive(0, 0, '0, 0, 0);
    checks++;
    if (dec_valid !== 2'b11) begin
      errors++;
      $display("FAIL async_reset_pre: got v=%b, expected v=11", dec_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({fetch_ready, dec_valid, dec_instr, dec_pc} !== {1'b1, {DW{1'b0}}, {32*DW{1'b0}}, {64*DW{1'b0}}}) begin
      errors++;
      $display("FAIL async_reset: got rdy=%b v=%b i=%h pc=%h, expected rdy=1 and all dec outputs 0", fetch_ready, dec_valid, dec_instr, dec_pc);
    end
    mq_i.delete(); mq_p.delete();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

`ifdef ALIGN_BUF_BYPASS_EN
  task automatic test_bypass();
    drive(0, 0, '0, 0, 1); tick();
    drive(1, 64'h2000, {32'h22, 32'h11}, 1, 0);
    checks++;
    if ({dec_valid, dec_instr, dec_pc} !== {2'b11, 32'h22, 32'h11, 64'h2004, 64'h2000}) begin
      errors++;
      $display("FAIL bypass_same_cycle: got v=%b i=%h pc=%h", dec_valid, dec_instr, dec_pc);
    end
    tick();
    drive(0, 0, '0, 0, 0);
    checks++;
    if (dec_valid !== 2'b00) begin
      errors++;
      $display("FAIL bypass_not_stored: got v=%b, expected v=00", dec_valid);
    end
    tick();
  endtask
`endif

  task automatic test_random();
    drive(0, 0, '0, 0, 1); tick();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 9) < 7, {$urandom, $urandom}, rand_block(),
            $urandom_range(0, 9) < 5, $urandom_range(0, 19) == 0);
      checks++;
      if ({fetch_ready, dec_valid, dec_instr, dec_pc} !== {exp_ready, exp_valid, exp_instr, exp_pc}) begin
        errors++;
        $display("FAIL random c%0d: got rdy=%b v=%b i=%h pc=%h, expected rdy=%b v=%b i=%h pc=%h", c, fetch_ready, dec_valid, dec_instr, dec_pc, exp_ready, exp_valid, exp_instr, exp_pc);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_misaligned();
    test_fill();
    test_wrap();
    test_flush();
`ifdef ALIGN_BUF_BYPASS_EN
    test_bypass();
`endif
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_align_buffer.md
# instr_align_buffer

Parametrised fetch-to-decode alignment queue. Each accepted fetch block of FETCH_WIDTH 32-bit instructions is aligned on the fetch PC, with lanes below the PC offset discarded. Surviving instructions are tagged with their own PC and pushed into a circular buffer. Decode drains up to DEC_WIDTH instructions per cycle. The block sits between the icache fetch stage and the decoder and supersedes the single-cycle, unbuffered 2-lane aligner.

## Interface
- FETCH_WIDTH, 2, instructions per fetch block; power of 2, at least 2.
- DEC_WIDTH, 2, maximum instructions presented to decode per cycle; at most DEPTH.
- DEPTH, 8, buffer entries; power of 2, at least FETCH_WIDTH.
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  redirect; discard all buffered and incoming instructions.
- fetch_valid  in  1  fetch block present.
- fetch_ready  out  1  block can accept a full fetch block.
- fetch_instr  in  32*FETCH_WIDTH  lane i at bits [32i+31:32i].
- fetch_pc  in  64  PC of first wanted instruction; bits [1:0] ignored.
- dec_valid  out  DEC_WIDTH  per-lane valid; always contiguous from lane 0.
- dec_instr  out  32*DEC_WIDTH  instructions in program order, lane 0 oldest.
- dec_pc  out  64*DEC_WIDTH  PC of each dec lane.
- dec_ready  in  1  decode consumes all lanes with dec_valid set this cycle.

## Operation
- L = log2(FETCH_WIDTH). off = fetch_pc[L+1:2]. Lanes off..FETCH_WIDTH-1 are valid. Lane i PC = {fetch_pc[63:L+2], i[L-1:0], 2'b00}.
- Push: fetch_valid & fetch_ready & !flush. Writes the FETCH_WIDTH-off valid lanes to consecutive entries at wr_ptr, then advances wr_ptr and count by FETCH_WIDTH-off.
- Pop: dec_ready & !flush. Removes popcnt = min(count, DEC_WIDTH) entries from rd_ptr.
- dec lane j shows entry rd_ptr+j (mod DEPTH) with dec_valid[j] = (j < count) & !flush. Unused lanes drive instr 0 and pc 0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Simultaneous push and pop: count_next = count + pushed - popped. Entry storage is written and read independently.
- flush: wr_ptr, rd_ptr and count go to 0 at the next edge. Any fetch in the flush cycle is dropped. dec_valid is forced to 0 in the flush cycle. flush overrides push and pop.
- fetch_ready = (DEPTH - count) >= FETCH_WIDTH, computed from registered count only. It has no combinational path from dec_ready or fetch_valid.
- dec_ready with dec_valid == 0 is a no-op.

## Timing
- Reset values: count=0, wr_ptr=0, rd_ptr=0, dec_valid=0, dec_instr=0, dec_pc=0, fetch_ready=1. Entry storage is not reset.
- Push-to-dec latency: 1 cycle. An instruction written at edge t is visible on dec at t+ (without bypass).
- Full: count > DEPTH-FETCH_WIDTH holds fetch_ready=0 even if decode pops in the same cycle.
- Reset asserted mid-operation clears state asynchronously. Outputs return to reset values immediately.

## Configuration
- ALIGN_BUF_BYPASS_EN defined:
  - When count==0 and a push occurs (not flush), dec lanes show the aligned incoming lanes combinationally in the same cycle.
  - If dec_ready is also asserted, the min(pushed, DEC_WIDTH) consumed lanes are not written to the buffer. Only the remainder is stored.
  - This adds a combinational path from fetch_* to dec_*.
- Undefined: dec outputs come only from buffer state, giving the 1-cycle latency above.

## Test plan
Defaults FETCH_WIDTH=2, DEC_WIDTH=2, DEPTH=8, bypass off unless stated.
- Aligned push, fetch_pc=0x1000, instr {0xB,0xA} -> next cycle dec_valid=2'b11, instr A@0x1000, B@0x1004. With dec_ready=1, count returns to 0.
- Misaligned push, fetch_pc=0x1004, instr {0xB,0xA} -> only B is stored: dec_valid=2'b01, dec_pc[0]=0x1004, count=1.
- Fill with dec_ready=0: 4 aligned pushes -> count=8, fetch_ready=0. A fifth fetch_valid is not accepted. One pop makes count=6 and fetch_ready=1 the following cycle.
- Wrap-around: 20 cycles of continuous push and pop with alternating misaligned PCs -> order and PCs are preserved across pointer wrap, and count never exceeds 8.
- flush with count=5 and fetch_valid=1 in the same cycle -> dec_valid=0 that cycle, count=0 next cycle, and the incoming block is never seen on dec.
- Bypass (ALIGN_BUF_BYPASS_EN), empty buffer, push fetch_pc=0x2000 with dec_ready=1 -> dec_valid=2'b11 in the same cycle, and count stays 0.
